sync_fifo_write_arbiter: RTL and testbench

SYNC_FIFO_WRITE_ARBITER -- requirements
Module: sync_fifo_write_arbiter

---
 rtl/sync_fifo_arb_pkg.sv | 12 +
 rtl/rr_priority_picker.sv | 31 +++
 rtl/sync_fifo_write_arbiter.sv | 121 ++++++++++++
 tb/tb_sync_fifo_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and stats counter width.
// Optional per-producer beat statistics are enabled by defining FIFO_ARB_STATS_EN.
package sync_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner search: first set request bit at or above ptr_i, wrapping to 0.
module rr_priority_picker #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    winner_o,
  output logic             valid_o
);

  int          j;
  logic [IW-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    j        = 0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IW'(j);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// Round-robin arbiter feeding N_REQ bursting producers into one sync FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-producer accepted-beat counters on wr_count_o.
module sync_fifo_write_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
  input  logic [N_REQ-1:0]              last_i,
  output logic [N_REQ-1:0]              ack_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_write_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic [$clog2(N_REQ)-1:0]      grant_id_o,
  output logic                          busy_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STATS_W-1:0]      wr_count_o
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [IW-1:0] pick_id;
  logic          pick_valid;
  logic [IW-1:0] owner_inc;
  logic          release_grant;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_id),
    .valid_o  (pick_valid)
  );

  assign busy_o       = (state_q == GRANT);
  assign grant_id_o   = owner_q;
  assign fifo_write_o = busy_o & req_i[owner_q] & ~fifo_full_i;
  assign owner_inc    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    ack_o          = '0;
    ack_o[owner_q] = fifo_write_o;
    fifo_wr_data_o = busy_o ? data_i[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // A dropped request, a last beat and a full burst all funnel into one release.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_d        = beat_q;
    release_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_id;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[owner_q]) begin
          release_grant = 1'b1;
        end else if (fifo_write_o) begin
          beat_d = beat_q + 1'b1;
          if (last_i[owner_q] || (beat_d == CW'(MAX_BURST))) release_grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (release_grant) begin
      state_d  = IDLE;
      rr_ptr_d = owner_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] wr_cnt_q [N_REQ];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_REQ; k++) wr_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (ack_o[k]) wr_cnt_q[k] <= wr_cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    wr_count_o = '0;
    for (int k = 0; k < N_REQ; k++) wr_count_o[k*STATS_W +: STATS_W] = wr_cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Directed bench for sync_fifo_write_arbiter (4 producers, 32-bit data, bursts of 4).
module tb_sync_fifo_write_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   last;
  logic         full;
  logic [3:0]   ack;
  logic         wr;
  logic [31:0]  wdata;
  logic [1:0]   gid;
  logic         busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0]  wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit data_mode = 1'b0;

  sync_fifo_write_arbiter #(
    .DATA_WIDTH (32),
    .N_REQ      (4),
    .MAX_BURST  (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .data_i         (data),
    .last_i         (last),
    .ack_o          (ack),
    .fifo_full_i    (full),
    .fifo_write_o   (wr),
    .fifo_wr_data_o (wdata),
    .grant_id_o     (gid),
    .busy_o         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count_o     (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dv(input int k);
    if (data_mode) return k * 32'h1111;
    return 32'hC0DE_0000 | k;
  endfunction

  task automatic load_data();
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = dv(k);
  endtask

  // Inputs are set one time unit after a rising edge; outputs are checked one unit later.
  task automatic cyc(input string tag, input logic eb, input logic [1:0] eid,
                     input logic ew, input logic [3:0] eack, input logic [31:0] ed);
    #1;
    check({tag, ".busy"}, busy, eb);
    check({tag, ".wr"}, wr, ew);
    check({tag, ".ack"}, ack, eack);
    check({tag, ".data"}, wdata, ed);
    if (eb) check({tag, ".id"}, gid, eid);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    last = '0;
    full = 1'b0;
    load_data();
    repeat (2) @(posedge clk);
    #1;
    check("reset.gid", gid, 2'd0);
    cyc("reset", 0, 0, 0, 4'b0000, 0);

    rst = 1'b0;
    req = 4'b0101;
    cyc("r30.idle", 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) cyc("r30.o0", 1, 0, 1, 4'b0001, dv(0));
    cyc("r30.bub1", 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) cyc("r30.o2", 1, 2, 1, 4'b0100, dv(2));
    cyc("r30.bub2", 0, 0, 0, 4'b0000, 0);
    cyc("r30.o0b", 1, 0, 1, 4'b0001, dv(0));
    req = 4'b0000;
    cyc("r30.drop", 1, 0, 0, 4'b0000, dv(0));
    cyc("r30.end", 0, 0, 0, 4'b0000, 0);

    req = 4'b0010;
    cyc("r31.idle", 0, 0, 0, 4'b0000, 0);
    cyc("r31.b1", 1, 1, 1, 4'b0010, dv(1));
    last = 4'b0010;
    cyc("r31.b2", 1, 1, 1, 4'b0010, dv(1));
    req  = 4'b0000;
    last = 4'b0000;
    cyc("r31.rel", 0, 0, 0, 4'b0000, 0);
    req = 4'b1111;
    cyc("r31.arb", 0, 0, 0, 4'b0000, 0);
    cyc("r31.ptr2", 1, 2, 1, 4'b0100, dv(2));
    req = 4'b0000;
    cyc("r31.drop", 1, 2, 0, 4'b0000, dv(2));
    cyc("r31.end", 0, 0, 0, 4'b0000, 0);

    req = 4'b1000;
    cyc("r32.idle", 0, 0, 0, 4'b0000, 0);
    cyc("r32.b1", 1, 3, 1, 4'b1000, dv(3));
    full = 1'b1;
    for (int i = 0; i < 5; i++) cyc("r32.stall", 1, 3, 0, 4'b0000, dv(3));
    full = 1'b0;
    for (int i = 0; i < 3; i++) cyc("r32.resume", 1, 3, 1, 4'b1000, dv(3));
    req = 4'b0000;
    cyc("r32.done", 0, 0, 0, 4'b0000, 0);

    data_mode = 1'b1;
    load_data();
    req = 4'b1111;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        cyc("r33.bub", 0, 0, 0, 4'b0000, 0);
        for (int b = 0; b < 4; b++)
          cyc("r33.grant", 1, 2'(order[g]), 1, 4'(1 << order[g]), dv(order[g]));
      end
    end
    req = 4'b0000;
    cyc("r33.end", 0, 0, 0, 4'b0000, 0);
    data_mode = 1'b0;
    load_data();

    req = 4'b0110;
    cyc("lastmax.idle", 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 3; i++) cyc("lastmax.o1", 1, 1, 1, 4'b0010, dv(1));
    last = 4'b0010;
    cyc("lastmax.b4", 1, 1, 1, 4'b0010, dv(1));
    last = 4'b0000;
    cyc("lastmax.bub", 0, 0, 0, 4'b0000, 0);
    cyc("lastmax.o2", 1, 2, 1, 4'b0100, dv(2));
    req = 4'b0000;
    cyc("lastmax.drop", 1, 2, 0, 4'b0000, dv(2));
    cyc("lastmax.end", 0, 0, 0, 4'b0000, 0);

    req = 4'b0010;
    cyc("r34.idle", 0, 0, 0, 4'b0000, 0);
    cyc("r34.b1", 1, 1, 1, 4'b0010, dv(1));
    rst = 1'b1;
    #1;
    check("r34.gid", gid, 2'd0);
    cyc("r34.rst", 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;
    req = 4'b1111;
    cyc("r34.idle2", 0, 0, 0, 4'b0000, 0);
    cyc("r34.restart", 1, 0, 1, 4'b0001, dv(0));
    req = 4'b0000;
    cyc("r34.drop", 1, 0, 0, 4'b0000, dv(0));
    cyc("r34.end", 0, 0, 0, 4'b0000, 0);

`ifdef FIFO_ARB_STATS_EN
    rst = 1'b1;
    #1;
    check("stats.rst", wr_count, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0100;
    begin
      int beats = 0;
      int cycles = 0;
      while (beats < 70000 && cycles < 99000) begin
        #1;
        if (ack[2]) beats++;
        @(posedge clk);
        #1;
        cycles++;
      end
      req = 4'b0000;
      check("stats.beats", beats, 70000);
    end
    #1;
    check("stats.p2", wr_count[2*16 +: 16], 70000 % 65536);
    check("stats.others", {wr_count[3*16 +: 16], wr_count[1*16 +: 16], wr_count[0 +: 16]}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
